ofm_requant_drain: RTL and testbench

//   Downstream of the conv accelerator top. Accepts the four 16-lane x 32-bit OFM psum ports,

---
 rtl/ofm_requant_drain_pkg.sv | 46 ++++
 rtl/ofm_requant_drain_if.sv | 22 ++
 rtl/ofm_group_fifo.sv | 57 +++++
 rtl/ofm_requant_drain.sv | 163 ++++++++++++++++
 tb/tb_ofm_requant_drain.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofm_requant_drain_pkg.sv
// Shared constants, serializer state and int8 requantizer for OFM output stages.
// requant(): optional ReLU, round-half-up arithmetic shift, saturate to int8.
package ofm_requant_drain_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 16;
    localparam int NPORT  = 4;
    localparam int OUT_W  = 8;
    localparam int PORT_W = $clog2(NPORT);
    localparam int ROW_W  = LANES * OUT_W;
    localparam int GRP_W  = NPORT * ROW_W + NPORT;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } ser_state_t;

    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [DATA_W-1:0] psum,
        input logic [4:0]               shift,
        input logic                     relu
    );
        logic signed [DATA_W:0] x;
        logic signed [DATA_W:0] rnd;
        logic signed [DATA_W:0] y;
        x = {psum[DATA_W-1], psum};
        if (relu && psum[DATA_W-1]) begin
            x = '0;
        end
        // one extra bit keeps x + rnd from wrapping at the top of the range
        rnd = '0;
        y = x;
        if (shift != 5'd0) begin
            rnd[shift - 5'd1] = 1'b1;
            y = (x + rnd) >>> shift;
        end
        if (y > 127) begin
            requant = 8'sd127;
        end else if (y < -128) begin
            requant = -8'sd128;
        end else begin
            requant = y[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/ofm_requant_drain_if.sv
// Output beat stream: int8 lane row, source port, tile-last, valid/ready.
// master drives data/port/last/valid and samples ready; slave is the sink.
interface ofm_requant_drain_if;
    import ofm_requant_drain_pkg::*;

    logic [ROW_W-1:0]  m_data;
    logic [PORT_W-1:0] m_port;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data, m_port, m_last, m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data, m_port, m_last, m_valid,
        output m_ready
    );

endinterface

// File: rtl/ofm_group_fifo.sv
// Synchronous group FIFO with occupancy count, full and empty flags.
// Ports: push/din write, pop reads head dout; a push is taken when full if popping.
module ofm_group_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr;
    logic          rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr && !rd) begin
                count <= count + 1'b1;
            end else if (!wr && rd) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ofm_requant_drain.sv
// Requantizes four 16-lane psum ports to int8, queues groups, serializes beats.
// Ports: cfg_*, in_port0..3/in_v0..3, end_op in; stall, done, err_ovf out; m stream.
module ofm_requant_drain
    import ofm_requant_drain_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              cfg_shift,
    input  logic                    cfg_relu,
    input  logic [15:0]             cfg_tile_beats,
    input  logic [LANES*DATA_W-1:0] in_port0,
    input  logic [LANES*DATA_W-1:0] in_port1,
    input  logic [LANES*DATA_W-1:0] in_port2,
    input  logic [LANES*DATA_W-1:0] in_port3,
    input  logic                    in_v0,
    input  logic                    in_v1,
    input  logic                    in_v2,
    input  logic                    in_v3,
    input  logic                    end_op,
    output logic                    stall,
    ofm_requant_drain_if.master     m,
    output logic                    done,
    output logic                    err_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NPORT-1:0]        in_v;
    logic [LANES*DATA_W-1:0] in_port [NPORT];
    logic                    s1_valid;
    logic [NPORT-1:0]        s1_mask;
    logic [NPORT*ROW_W-1:0]  s1_data;
    logic [NPORT*ROW_W-1:0]  s1_next;
    logic [GRP_W-1:0]        head;
    logic [AW:0]             count;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    fire;
    logic                    end_lat;
    logic [15:0]             bcnt;
    logic [15:0]             tile_m1;
    ser_state_t              state;
    ser_state_t              state_n;
    logic [NPORT-1:0]        pend;
    logic [NPORT-1:0]        pend_n;
    logic [NPORT-1:0]        cur_mask;
    logic [NPORT-1:0]        rest;
    logic [PORT_W-1:0]       port_sel;

    assign in_v       = {in_v3, in_v2, in_v1, in_v0};
    assign in_port[0] = in_port0;
    assign in_port[1] = in_port1;
    assign in_port[2] = in_port2;
    assign in_port[3] = in_port3;

    always_comb begin
        s1_next = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int l = 0; l < LANES; l++) begin
                s1_next[(p*LANES+l)*OUT_W +: OUT_W] =
                    requant(in_port[p][l*DATA_W +: DATA_W], cfg_shift, cfg_relu);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mask  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= |in_v;
            if (|in_v) begin
                s1_mask <= in_v;
                s1_data <= s1_next;
            end
        end
    end

    ofm_group_fifo #(
        .W     (GRP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid),
        .din   ({s1_mask, s1_data}),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // In IDLE the head entry is presented straight from the FIFO so a fresh
    // group (or the next one after a pop) costs no bubble cycle.
    assign cur_mask = (state == S_EMIT) ? pend : head[GRP_W-1 -: NPORT];

    always_comb begin
        port_sel = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (cur_mask[i]) begin
                port_sel = PORT_W'(i);
            end
        end
    end

    assign rest      = cur_mask & ~(NPORT'(1) << port_sel);
    assign tile_m1   = (cfg_tile_beats == 16'd0) ? 16'd0 : cfg_tile_beats - 16'd1;
    assign m.m_valid = !empty;
    assign m.m_port  = m.m_valid ? port_sel : '0;
    assign m.m_data  = m.m_valid ? head[port_sel*ROW_W +: ROW_W] : '0;
    assign m.m_last  = m.m_valid && (bcnt == tile_m1);
    assign fire      = m.m_valid && m.m_ready;

    always_comb begin
        state_n = state;
        pend_n  = pend;
        pop     = 1'b0;
        if (fire) begin
            if (rest == '0) begin
                pop     = 1'b1;
                state_n = S_IDLE;
            end else begin
                pend_n  = rest;
                state_n = S_EMIT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pend  <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
        end
    end

    assign done = end_lat && !s1_valid && empty && (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall   <= 1'b0;
            err_ovf <= 1'b0;
            end_lat <= 1'b0;
            bcnt    <= '0;
        end else begin
            stall   <= (32'(count) + 32'(s1_valid)) >= FIFO_DEPTH - 2;
            err_ovf <= err_ovf | (s1_valid && full && !pop);
            end_lat <= end_op | (end_lat & ~done);
            if (done) begin
                bcnt <= '0;
            end else if (fire) begin
                bcnt <= m.m_last ? 16'd0 : bcnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ofm_requant_drain.sv
// Randomized bench for ofm_requant_drain against a plain-arithmetic beat model.
// Expected beats queue in send order; a negedge monitor scores every handshake.
module tb_ofm_requant_drain;

    typedef struct packed {
        logic [1:0]   port;
        logic [127:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   cfg_shift = '0;
    logic         cfg_relu = 1'b0;
    logic [15:0]  cfg_tile_beats = '0;
    logic [511:0] in_port0 = '0;
    logic [511:0] in_port1 = '0;
    logic [511:0] in_port2 = '0;
    logic [511:0] in_port3 = '0;
    logic         in_v0 = 1'b0;
    logic         in_v1 = 1'b0;
    logic         in_v2 = 1'b0;
    logic         in_v3 = 1'b0;
    logic         end_op = 1'b0;
    logic         stall;
    logic         done;
    logic         err_ovf;

    ofm_requant_drain_if bus();

    ofm_requant_drain dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_shift      (cfg_shift),
        .cfg_relu       (cfg_relu),
        .cfg_tile_beats (cfg_tile_beats),
        .in_port0       (in_port0),
        .in_port1       (in_port1),
        .in_port2       (in_port2),
        .in_port3       (in_port3),
        .in_v0          (in_v0),
        .in_v1          (in_v1),
        .in_v2          (in_v2),
        .in_v3          (in_v3),
        .end_op         (end_op),
        .stall          (stall),
        .m              (bus.master),
        .done           (done),
        .err_ovf        (err_ovf)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_fail = 0;
    beat_t  exp_q[$];
    int     lv[4][16];
    int     bcnt_m = 0;
    int     cyc = 0;
    int     last_hs_cyc = -1;
    int     done_cyc = -1;
    int     done_cnt = 0;
    int     last_cnt = 0;
    int     rdy_mode = 0;
    bit     hold_v = 0;
    logic [130:0] hold_d;

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // int8 requantization from the arithmetic definition (floor division)
    function automatic int ref_q(input int x, input int sh, input bit relu);
        longint v;
        longint d;
        v = x;
        if (relu && v < 0) v = 0;
        if (sh > 0) begin
            d = longint'(1) << sh;
            v = v + d / 2;
            if (v >= 0) v = v / d;
            else v = -((-v + d - 1) / d);
        end
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = 1'b0;
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        beat_t e;
        bit    el;
        int    tile;
        if (rst) begin
            hold_v = 0;
        end else begin
            if (hold_v)
                chk("hold", {bus.m_valid, bus.m_port, bus.m_last, bus.m_data},
                    {1'b1, hold_d});
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {bus.m_port, bus.m_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {bus.m_port, bus.m_data}, e);
                    tile = (cfg_tile_beats == 0) ? 1 : int'(cfg_tile_beats);
                    el = (bcnt_m == tile - 1);
                    chk("last", bus.m_last, el);
                    bcnt_m = el ? 0 : bcnt_m + 1;
                end
                if (bus.m_last) last_cnt++;
                last_hs_cyc = cyc;
            end
            hold_v = bus.m_valid && !bus.m_ready;
            hold_d = {bus.m_port, bus.m_last, bus.m_data};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                bcnt_m = 0;
            end
        end
    end

    task automatic fill_const(input int v);
        for (int p = 0; p < 4; p++)
            for (int l = 0; l < 16; l++) lv[p][l] = v;
    endtask

    task automatic fill_rand();
        for (int p = 0; p < 4; p++)
            for (int l = 0; l < 16; l++)
                case ($urandom_range(0, 2))
                    0: lv[p][l] = int'($urandom_range(0, 600)) - 300;
                    1: lv[p][l] = int'($urandom);
                    default: lv[p][l] = int'($urandom_range(0, 70000)) - 35000;
                endcase
    endtask

    task automatic send(input logic [3:0] mask, input bit acc);
        beat_t b;
        for (int l = 0; l < 16; l++) begin
            in_port0[l*32 +: 32] = lv[0][l];
            in_port1[l*32 +: 32] = lv[1][l];
            in_port2[l*32 +: 32] = lv[2][l];
            in_port3[l*32 +: 32] = lv[3][l];
        end
        {in_v3, in_v2, in_v1, in_v0} = mask;
        if (acc) begin
            for (int p = 0; p < 4; p++) begin
                if (mask[p]) begin
                    b.port = 2'(p);
                    for (int l = 0; l < 16; l++)
                        b.data[l*8 +: 8] = 8'(ref_q(lv[p][l], int'(cfg_shift), cfg_relu));
                    exp_q.push_back(b);
                end
            end
        end
        tick();
        {in_v3, in_v2, in_v1, in_v0} = 4'b0000;
    endtask

    task automatic drain();
        for (int k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0 && !bus.m_valid) break;
            tick();
        end
        repeat (3) tick();
        chk("drain_left", exp_q.size(), 0);
        chk("drain_valid", bus.m_valid, 0);
    endtask

    task automatic probe(input string tag, input logic [31:0] exp);
        send(4'b0001, 1);
        tick();
        chk({tag, "_lanes"}, bus.m_data[31:0], exp);
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        bcnt_m = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic [3:0] mk;
        bus.m_ready = 1'b1;
        do_reset();
        chk("rst_stall", stall, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_data", {bus.m_port, bus.m_last, bus.m_data}, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", err_ovf, 0);

        // single port, latency and saturation
        cfg_shift = 5'd2;
        fill_const(300);
        send(4'b0001, 1);
        chk("lat_t1", bus.m_valid, 0);
        tick();
        chk("lat_t2", bus.m_valid, 1);
        chk("t1_port", bus.m_port, 0);
        chk("t1_lane0", bus.m_data[7:0], 8'd75);
        drain();
        fill_const(1000);
        probe("sat_hi", 32'h7F7F7F7F);

        // rounding and relu
        cfg_shift = 5'd1;
        for (int l = 0; l < 16; l += 4) begin
            lv[0][l] = -5; lv[0][l+1] = 5; lv[0][l+2] = -6; lv[0][l+3] = 6;
        end
        probe("round", 32'h03FD03FE);
        cfg_relu = 1'b1;
        probe("relu", 32'h03000300);
        cfg_relu = 1'b0;
        cfg_shift = 5'd0;
        lv[0][0] = 32'h7FFFFFFF;
        lv[0][1] = 32'h80000000;
        lv[0][2] = 0;
        lv[0][3] = -1;
        probe("extreme", 32'hFF00807F);

        // back-pressure with all ports and sink stalled
        rdy_mode = 1;
        cfg_shift = 5'd4;
        tick();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (stall) break;
            fill_rand();
            send(4'hF, 1);
            n++;
        end
        repeat (2) tick();
        chk("stall_groups", n, 7);
        chk("stall_high", stall, 1);
        chk("no_ovf", err_ovf, 0);
        rdy_mode = 0;
        drain();

        // sparse mask, random ready, random config
        rdy_mode = 2;
        fill_rand();
        send(4'b1010, 1);
        for (int g = 0; g < 40; g++) begin
            if (stall) begin
                tick();
                continue;
            end
            if ($urandom_range(0, 4) == 0)
                cfg_shift = 5'($urandom_range(0, 31));
            else
                cfg_shift = 5'($urandom_range(0, 10));
            cfg_relu = 1'($urandom_range(0, 1));
            mk = 4'($urandom_range(1, 15));
            fill_rand();
            send(mk, 1);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        // tile boundaries and end_op
        do_reset();
        cfg_tile_beats = 16'd6;
        cfg_shift = 5'd3;
        last_cnt = 0;
        done_cnt = 0;
        for (int g = 0; g < 6; g++) begin
            while (stall) tick();
            fill_rand();
            send(4'b0011, 1);
        end
        end_op = 1'b1;
        tick();
        end_op = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (done_cnt > 0) break;
            tick();
        end
        repeat (5) tick();
        chk("done_cnt", done_cnt, 1);
        chk("done_lat", done_cyc, last_hs_cyc + 1);
        chk("last_cnt", last_cnt, 2);
        chk("q_after_done", exp_q.size(), 0);
        rdy_mode = 0;

        // overflow: ignore stall until the FIFO overruns
        cfg_tile_beats = 16'd0;
        rdy_mode = 1;
        tick();
        for (int g = 0; g < 10; g++) begin
            fill_rand();
            send(4'($urandom_range(1, 15)), g < 8);
        end
        repeat (3) tick();
        chk("ovf_set", err_ovf, 1);
        rdy_mode = 0;
        drain();
        repeat (10) tick();
        chk("ovf_sticky", err_ovf, 1);

        // asynchronous reset in the middle of a stalled beat
        rdy_mode = 1;
        tick();
        for (int g = 0; g < 9; g++) begin
            fill_rand();
            send(4'hF, 1);
        end
        repeat (3) tick();
        chk("pre_rst_valid", bus.m_valid, 1);
        chk("pre_rst_stall", stall, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        bcnt_m = 0;
        #1;
        chk("arst_valid", bus.m_valid, 0);
        chk("arst_stall", stall, 0);
        chk("arst_ovf", err_ovf, 0);
        tick();
        rst = 1'b0;
        rdy_mode = 0;
        repeat (5) tick();
        chk("post_rst_valid", bus.m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
